// File: rtl/commit_pkg.sv
// Shared types and constants for the commit tracker: FSM states, control-flow
// opcodes that permit a non-sequential next PC, and the default reset PC.
package commit_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_e;

  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [6:0]  OP_JAL       = 7'b1101111;
  localparam logic [6:0]  OP_JALR      = 7'b1100111;
  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;

  function automatic logic is_redirect(input logic [31:0] inst);
    return (inst[6:0] == OP_BRANCH) || (inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR);
  endfunction

endpackage

// File: rtl/shadow_regfile.sv
// 32x32 shadow register file: one write port, one combinational read port,
// x0 hardwired to zero, all entries cleared on synchronous reset.
module shadow_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra,
  output logic [31:0] o_rd
);

  logic [31:0] r_mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd = (i_ra == 5'd0) ? 32'd0 : r_mem[i_ra];

endmodule

// File: rtl/commit_tracker.sv
// Commit-interface monitor: shadow regfile, commit/cycle counters, PC flow
// checking, and halt/watchdog termination with sticky error flags.
module commit_tracker
  import commit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEF_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        global_en,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic [4:0]  shadow_ra,
  output logic [31:0] shadow_rd,
  output logic [31:0] commit_count,
  output logic [31:0] cycle_count,
  output logic [31:0] last_pc,
  output logic        done,
  output logic        timeout,
  output logic        pc_error,
  output logic        proto_error
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state, w_state_nxt;
  logic [31:0]       r_commit_cnt, r_cycle_cnt, r_last_pc;
  logic [WD_W-1:0]   r_wd;
  logic              r_prev_redir, r_pc_err, r_proto_err;
  logic              w_active, w_acc, w_expire, w_pc_bad;

  assign w_active = (r_state == IDLE) || (r_state == RUN);
  assign w_acc    = global_en && commit && w_active;
  // Expiry only when this edge would bring the watchdog to its limit and no
  // commit arrives to clear it.
  assign w_expire = global_en && w_active && !commit && (r_wd >= WD_LAST);
  assign w_pc_bad = (r_state == IDLE) ? (commit_pc != RESET_PC)
                                      : (!r_prev_redir && (commit_pc != r_last_pc + 32'd4));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RUN: begin
        if (w_acc)         w_state_nxt = commit_halt ? DONE : RUN;
        else if (w_expire) w_state_nxt = TIMEOUT;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_cnt <= '0;
      r_cycle_cnt  <= '0;
      r_last_pc    <= '0;
      r_wd         <= '0;
      r_prev_redir <= 1'b0;
      r_pc_err     <= 1'b0;
      r_proto_err  <= 1'b0;
    end else if (global_en) begin
      if (w_active) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
        if (w_acc)               r_wd <= '0;
        else if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
      end
      if (w_acc) begin
        r_commit_cnt <= r_commit_cnt + 32'd1;
        r_last_pc    <= commit_pc;
        r_prev_redir <= is_redirect(commit_inst);
        if (w_pc_bad) r_pc_err <= 1'b1;
      end
      if (commit && !w_active) r_proto_err <= 1'b1;
    end
  end

  shadow_regfile u_rf (
    .clk  (clk),
    .rst  (rst),
    .i_we (w_acc && commit_reg_we),
    .i_wa (commit_reg_wa),
    .i_wd (commit_reg_wd),
    .i_ra (shadow_ra),
    .o_rd (shadow_rd)
  );

  assign commit_count = r_commit_cnt;
  assign cycle_count  = r_cycle_cnt;
  assign last_pc      = r_last_pc;
  assign done         = (r_state == DONE);
  assign timeout      = (r_state == TIMEOUT);
  assign pc_error     = r_pc_err;
  assign proto_error  = r_proto_err;

endmodule

// File: tb/tb_commit_tracker.sv
// Directed bench for commit_tracker with a 16-cycle watchdog.
module tb_commit_tracker;
  import commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, global_en, commit, commit_halt, commit_reg_we;
  logic [31:0] commit_pc, commit_inst, commit_reg_wd;
  logic [4:0]  commit_reg_wa, shadow_ra;
  logic [31:0] shadow_rd, commit_count, cycle_count, last_pc;
  logic        done, timeout, pc_error, proto_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  commit_tracker #(.RESET_PC(32'h0040_0000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .global_en(global_en), .commit(commit),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_halt(commit_halt),
    .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd), .shadow_ra(shadow_ra), .shadow_rd(shadow_rd),
    .commit_count(commit_count), .cycle_count(cycle_count), .last_pc(last_pc),
    .done(done), .timeout(timeout), .pc_error(pc_error), .proto_error(proto_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; global_en = 1'b1; commit = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [31:0] inst, input logic halt,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
    commit = 1'b1; commit_pc = pc; commit_inst = inst; commit_halt = halt;
    commit_reg_we = we; commit_reg_wa = wa; commit_reg_wd = wd;
    tick(1);
    commit = 1'b0; commit_halt = 1'b0; commit_reg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; global_en = 1'b1; commit = 1'b0; commit_pc = '0; commit_inst = '0;
    commit_halt = 1'b0; commit_reg_we = 1'b0; commit_reg_wa = '0; commit_reg_wd = '0;
    shadow_ra = 5'd1;

    // Reset state
    do_reset();
    chk("rst_commit_count", commit_count, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_last_pc", last_pc, 32'd0);
    chk("rst_flags", {28'd0, done, timeout, pc_error, proto_error}, 32'd0);
    chk("rst_x1", shadow_rd, 32'd0);
    chk("rst_state", {30'd0, dut.r_state}, {30'd0, IDLE});

    // Sequential ADDI / ADD, plus no same-cycle bypass on x5
    do_commit(32'h0040_0000, 32'h0050_0093, 1'b0, 1'b1, 5'd1, 32'd5);
    do_commit(32'h0040_0004, 32'h0010_8133, 1'b0, 1'b1, 5'd2, 32'd10);
    shadow_ra = 5'd1; #1 chk("seq_x1", shadow_rd, 32'd5);
    shadow_ra = 5'd2; #1 chk("seq_x2", shadow_rd, 32'd10);
    chk("seq_count", commit_count, 32'd2);
    chk("seq_cycles", cycle_count, 32'd2);
    chk("seq_pc_error", {31'd0, pc_error}, 32'd0);
    chk("seq_last_pc", last_pc, 32'h0040_0004);
    shadow_ra = 5'd5;
    commit = 1'b1; commit_pc = 32'h0040_0008; commit_inst = 32'h0630_0293;
    commit_reg_we = 1'b1; commit_reg_wa = 5'd5; commit_reg_wd = 32'd99;
    #1 chk("nobypass_x5", shadow_rd, 32'd0);
    tick(1);
    commit = 1'b0; commit_reg_we = 1'b0;
    chk("after_x5", shadow_rd, 32'd99);

    // Wrong first PC
    do_reset();
    do_commit(32'h0040_0008, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("firstpc_error", {31'd0, pc_error}, 32'd1);
    chk("firstpc_count", commit_count, 32'd1);
    chk("firstpc_state", {30'd0, dut.r_state}, {30'd0, RUN});

    // JAL permits arbitrary target; plain ADDI followed by +8 does not
    do_reset();
    do_commit(32'h0040_0000, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    do_commit(32'h0040_0004, 32'h0000_006f, 1'b0, 1'b0, 5'd0, 32'd0);
    do_commit(32'h0040_0100, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("jal_no_error", {31'd0, pc_error}, 32'd0);
    do_commit(32'h0040_0108, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("plus8_error", {31'd0, pc_error}, 32'd1);
    chk("plus8_last_pc", last_pc, 32'h0040_0108);

    // x0 write dropped, then halt writing x3=7, then protocol error
    do_reset();
    do_commit(32'h0040_0000, 32'h0000_0013, 1'b0, 1'b1, 5'd0, 32'h1234);
    shadow_ra = 5'd0; #1 chk("x0_zero", shadow_rd, 32'd0);
    chk("x0_count", commit_count, 32'd1);
    do_commit(32'h0040_0004, 32'h0070_0193, 1'b1, 1'b1, 5'd3, 32'd7);
    shadow_ra = 5'd3; #1 chk("halt_x3", shadow_rd, 32'd7);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_count", commit_count, 32'd2);
    do_commit(32'h0040_0008, 32'h0000_0013, 1'b0, 1'b1, 5'd3, 32'd55);
    tick(1);
    chk("post_proto", {31'd0, proto_error}, 32'd1);
    chk("post_count", commit_count, 32'd2);
    chk("post_cycles", cycle_count, 32'd2);
    chk("post_x3", shadow_rd, 32'd7);
    chk("post_last_pc", last_pc, 32'h0040_0004);

    // global_en low freezes everything; read path still live
    do_reset();
    do_commit(32'h0040_0000, 32'h0050_0093, 1'b0, 1'b1, 5'd1, 32'd5);
    global_en = 1'b0;
    do_commit(32'h0040_0004, 32'h0010_8133, 1'b0, 1'b1, 5'd4, 32'd44);
    tick(3);
    shadow_ra = 5'd4; #1 chk("en_x4", shadow_rd, 32'd0);
    shadow_ra = 5'd1; #1 chk("en_x1_read", shadow_rd, 32'd5);
    chk("en_count", commit_count, 32'd1);
    chk("en_cycles", cycle_count, 32'd1);
    global_en = 1'b1;

    // Watchdog: 16 idle enabled cycles
    do_reset();
    tick(15);
    chk("wd15_timeout", {31'd0, timeout}, 32'd0);
    tick(1);
    chk("wd16_timeout", {31'd0, timeout}, 32'd1);
    chk("wd16_cycles", cycle_count, 32'd16);
    tick(3);
    chk("wd_cycles_frozen", cycle_count, 32'd16);
    do_commit(32'h0040_0000, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("wd_proto", {31'd0, proto_error}, 32'd1);
    chk("wd_count", commit_count, 32'd0);

    // Watchdog paused while global_en low: expiry after 26 edges
    do_reset();
    tick(5);
    global_en = 1'b0; tick(10);
    global_en = 1'b1; tick(10);
    chk("wdpause_25", {31'd0, timeout}, 32'd0);
    tick(1);
    chk("wdpause_26", {31'd0, timeout}, 32'd1);
    chk("wdpause_cycles", cycle_count, 32'd16);

    // Commit on the 16th cycle beats expiry and restarts the watchdog
    do_reset();
    tick(15);
    do_commit(32'h0040_0000, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("race_timeout", {31'd0, timeout}, 32'd0);
    chk("race_count", commit_count, 32'd1);
    tick(15);
    chk("race_wd15", {31'd0, timeout}, 32'd0);
    tick(1);
    chk("race_wd16", {31'd0, timeout}, 32'd1);

    // Reset from a terminal state with global_en low
    global_en = 1'b0;
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("midrst_state", {30'd0, dut.r_state}, {30'd0, IDLE});
    chk("midrst_flags", {28'd0, done, timeout, pc_error, proto_error}, 32'd0);
    chk("midrst_count", commit_count, 32'd0);
    chk("midrst_cycles", cycle_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
